// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch front end: jump opcodes and a clog2 helper
// used to size queue pointers and credit counters.
package fetch_unit_pkg;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding {pc, data} prefetch entries; the head is read
// combinationally so a word written this cycle is visible the next cycle.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       srst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [clog2(DEPTH):0]      count_o,
    output logic                       head_valid_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop; the caller never pushes into a full queue.
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    always_ff @(posedge clk) begin
        if (srst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !srst_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != '0);
    assign head_o       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited requests, in-order responses into a
// prefetch queue, redirect flush. Optional J/JAL predecode under FETCH_JUMP_PREDECODE_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    localparam int              CNT_W        = clog2(DEPTH) + 1;
    localparam int              ENTRY_W      = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W:0]  CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      discard_q, discard_d;

    logic [CNT_W-1:0]      q_count;
    logic                  q_head_valid;
    logic [ENTRY_W-1:0]    q_head;
    logic                  q_push;
    logic                  q_flush;
    logic [CNT_W:0]        in_flight;
    logic                  req_fire;
    logic                  resp_keep;
    logic                  jump_hit;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [ADDR_WIDTH-1:0] redirect_aligned;

    // Queued words plus in-flight requests never exceed DEPTH, so a response always has a slot.
    assign in_flight        = {1'b0, q_count} + {1'b0, outstanding_q};
    assign imem_req_valid   = !reset && (in_flight < CREDIT_LIMIT);
    assign imem_req_addr    = fetch_pc_q;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign resp_keep        = imem_resp_valid && (discard_q == '0);
    assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

`ifdef FETCH_JUMP_PREDECODE_EN
    localparam logic [ADDR_WIDTH-1:0] REGION_MASK = ~ADDR_WIDTH'(28'hFFF_FFFF);
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [5:0]            resp_op;

    assign pc_plus4    = resp_pc_q + ADDR_WIDTH'(4);
    assign resp_op     = imem_resp_data[31:26];
    assign jump_hit    = resp_keep && ((resp_op == OP_J) || (resp_op == OP_JAL));
    assign jump_target = (pc_plus4 & REGION_MASK) | ADDR_WIDTH'({imem_resp_data[25:0], 2'b00});
`else
    assign jump_hit    = 1'b0;
    assign jump_target = '0;
`endif

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
        discard_d     = discard_q;
        q_push        = 1'b0;
        q_flush       = 1'b0;

        if (imem_resp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end
        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        end
        if (resp_keep) begin
            q_push    = 1'b1;
            resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
        end

        // Every request still in flight after this cycle belongs to the old path.
        if (redirect_valid) begin
            q_flush    = 1'b1;
            q_push     = 1'b0;
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            discard_d  = outstanding_d;
        end else if (jump_hit) begin
            // Older queued words and the jump itself precede the target, so the queue is kept.
            fetch_pc_d = jump_target;
            resp_pc_d  = jump_target;
            discard_d  = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .srst_i       (reset),
        .push_i       (q_push),
        .push_data_i  ({resp_pc_q, imem_resp_data}),
        .pop_i        (inst_valid && inst_ready),
        .flush_i      (q_flush),
        .count_o      (q_count),
        .head_valid_o (q_head_valid),
        .head_o       (q_head)
    );

    assign inst_valid = q_head_valid && !reset;
    assign inst_pc    = q_head[ENTRY_W-1:DATA_WIDTH];
    assign inst_data  = q_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural variable-latency memory,
// a scoreboard of expected {pc, data} deliveries, and a redirect vector table.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_inst_valid;
    logic [31:0] w_inst_data, w_inst_pc;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
        .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_inst_valid), .inst_ready(1'b0), .inst_data(w_inst_data), .inst_pc(w_inst_pc)
    );

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;
    int cyc      = 0;
    bit jump_en  = 1'b0;
    bit mon_en   = 1'b0;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { int pre; int lat; logic [31:0] rpc; logic [31:0] epc; int n; } vec_t;

    mreq_t mq[$];
    exp_t  expq[$];
    vec_t  vecs[5];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        if (jump_en && a == 32'h0) return 32'h0800_0040;
        return a ^ 32'hC35A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int k = 0; k < n; k++) begin
            expq.push_back('{pc: start + 32'(4 * k), data: data_of(start + 32'(4 * k))});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mon_en = 1'b0; expq.delete();
        tick(); tick();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int k;
        k = 0;
        while (expq.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(name, expq.size(), 32'd0);
        inst_ready = 1'b0;
        mon_en = 1'b0;
    endtask

    // Memory model: in-order responses, one per accepted request, mem_lat cycles after acceptance.
    initial begin : mem_model
        bit          s_req, s_resp, s_rst;
        logic [31:0] s_addr;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            s_req  = imem_req_valid && imem_req_ready;
            s_addr = imem_req_addr;
            s_resp = imem_resp_valid;
            s_rst  = reset;
            @(posedge clk);
            #1;
            cyc++;
            if (s_rst) begin
                mq.delete();
            end else begin
                if (s_resp && mq.size() > 0) void'(mq.pop_front());
                if (s_req) mq.push_back('{addr: s_addr, due: cyc + mem_lat - 1});
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = data_of(mq[0].addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // Delivery scoreboard: every decode handshake must match the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && inst_valid && inst_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_inst_pc", inst_pc, 32'hDEAD_BEEF);
                end else begin
                    e = expq.pop_front();
                    $display("inst pc=%h data=%h", inst_pc, inst_data);
                    check("inst_pc", inst_pc, e.pc);
                    check("inst_data", inst_data, e.data);
                end
            end
        end
    end

    initial begin : main
        int nreq;
        int guard;
        logic [31:0] new_addr;

        vecs[0] = '{pre: 3, lat: 5, rpc: 32'h0000_0100, epc: 32'h0000_0100, n: 4};
        vecs[1] = '{pre: 2, lat: 5, rpc: 32'h0000_0203, epc: 32'h0000_0200, n: 4};
        vecs[2] = '{pre: 6, lat: 2, rpc: 32'h0000_0040, epc: 32'h0000_0040, n: 5};
        vecs[3] = '{pre: 4, lat: 1, rpc: 32'hFFFF_FFF8, epc: 32'hFFFF_FFF8, n: 4};
        vecs[4] = '{pre: 3, lat: 3, rpc: 32'h0000_1000, epc: 32'h0000_1000, n: 6};

        imem_req_ready = 1'b1;

        // Sequential fetch at latency 1, plus the wrap-around instance.
        mem_lat = 1;
        do_reset();
        push_seq(32'h0, 16);
        mon_en = 1'b1;
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check("t1_req_addr", imem_req_addr, 32'(4 * k));
            if (k < 3) check("t5_wrap_addr", w_req_addr, 32'hFFFF_FFF8 + 32'(4 * k));
            if (k < 2) check("t1_inst_valid_early", {31'b0, inst_valid}, 32'd0);
            if (k == 2) begin
                check("t1_inst_valid_lat", {31'b0, inst_valid}, 32'd1);
                check("t1_first_pc", inst_pc, 32'h0);
            end
            if (k == 5) check("t5_credit_stop", {31'b0, w_req_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        wait_drained("t1_drain", 100);

        // Back-pressure: credit limit holds requests at DEPTH.
        mem_lat = 3;
        do_reset();
        expq.push_back('{pc: 32'h0, data: data_of(32'h0)});
        mon_en = 1'b1;
        nreq = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (imem_req_valid && imem_req_ready) nreq++;
            @(posedge clk);
            #1;
        end
        check("t2_req_count", 32'(nreq), 32'd4);
        check("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        check("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        nreq = 0;
        new_addr = '0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (imem_req_valid && imem_req_ready) begin
                nreq++;
                new_addr = imem_req_addr;
            end
            @(posedge clk);
            #1;
        end
        check("t2_one_more_req", 32'(nreq), 32'd1);
        check("t2_refill_addr", new_addr, 32'h10);
        check("t2_next_head", inst_pc, 32'h4);
        mon_en = 1'b0;

        // Redirect vectors with stale requests outstanding.
        for (int v = 0; v < 5; v++) begin
            mem_lat = vecs[v].lat;
            do_reset();
            push_seq(32'h0, 16);
            mon_en = 1'b1;
            inst_ready = 1'b1;
            repeat (vecs[v].pre) tick();
            redirect_valid = 1'b1;
            redirect_pc = vecs[v].rpc;
            tick();
            redirect_valid = 1'b0;
            $display("redirect vec %0d pc=%h", v, vecs[v].rpc);
            check("t3_fetch_pc", imem_req_addr, vecs[v].epc);
            expq.delete();
            push_seq(vecs[v].epc, vecs[v].n);
            wait_drained("t3_vec_drain", 300);
        end

        // Redirect coinciding with a response and a decode handshake.
        mem_lat = 1;
        do_reset();
        push_seq(32'h0, 16);
        mon_en = 1'b1;
        inst_ready = 1'b1;
        guard = 0;
        #1;
        while (!(imem_resp_valid && inst_valid) && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("t4_coincide_found", 32'(guard < 20), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h800;
        tick();
        redirect_valid = 1'b0;
        expq.delete();
        push_seq(32'h800, 4);
        check("t4_flushed", {31'b0, inst_valid}, 32'd0);
        check("t4_fetch_pc", imem_req_addr, 32'h800);
        tick();
        check("t4_stale_dropped", {31'b0, inst_valid}, 32'd0);
        wait_drained("t4_drain", 100);

        // Back-to-back redirects: latest wins.
        mem_lat = 4;
        do_reset();
        push_seq(32'h0, 16);
        mon_en = 1'b1;
        inst_ready = 1'b1;
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        check("t4b_first_target", imem_req_addr, 32'h300);
        redirect_pc = 32'h500;
        tick();
        redirect_valid = 1'b0;
        expq.delete();
        push_seq(32'h500, 4);
        wait_drained("t4b_drain", 200);

`ifdef FETCH_JUMP_PREDECODE_EN
        // Predecoded jump at pc 0 steers fetch to 0x100.
        jump_en = 1'b1;
        mem_lat = 1;
        do_reset();
        expq.push_back('{pc: 32'h0, data: 32'h0800_0040});
        push_seq(32'h100, 4);
        mon_en = 1'b1;
        inst_ready = 1'b1;
        wait_drained("t6_jump_drain", 100);
        jump_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
